// File: rtl/spram_arbiter.sv
// spram_arbiter: arbitrates two 32-bit requesters onto a 16K x 16 single-port SPRAM,
// running every granted access as a low-half cycle followed by a high-half cycle.
module spram_arbiter #(
    parameter int PRIO_A = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [3:0]  a_be,
    input  logic [12:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [3:0]  b_be,
    input  logic [12:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_ack,
    output logic [31:0] rdata,
    output logic [13:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, LO, HI, TAIL} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [12:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        port_reg;      // latched owner: 0 = A, 1 = B
    logic        last_b_reg;    // 1 when the most recent grant went to B
    logic [15:0] lo_reg;
    logic [31:0] rdata_reg;
    logic        a_ack_reg;
    logic        b_ack_reg;

    logic        arb_point;
    logic        grant_a;
    logic        grant_b;
    logic [3:0]  lo_mask;
    logic [3:0]  hi_mask;

    // Each byte enable covers two adjacent nibbles of its 16-bit half.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign lo_mask[gi] = be_reg[gi / 2];
        assign hi_mask[gi] = be_reg[2 + gi / 2];
    end

    assign arb_point = (state_reg == IDLE) || (state_reg == TAIL);

    // Grants are combinational; gating with rst_n keeps them low while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (arb_point && rst_n) begin
            if (a_req && b_req) begin
                grant_a = (PRIO_A != 0) || last_b_reg;
                grant_b = !grant_a;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_addr   = 14'h0000;
        mem_we     = 4'h0;
        mem_wdata  = 16'h0000;
        case (state_reg)
            IDLE: begin
                if (grant_a || grant_b) state_next = LO;
            end
            LO: begin
                state_next = HI;
                mem_addr   = {addr_reg, 1'b0};
                mem_wdata  = wdata_reg[15:0];
                mem_we     = we_reg ? lo_mask : 4'h0;
            end
            HI: begin
                state_next = TAIL;
                mem_addr   = {addr_reg, 1'b1};
                mem_wdata  = wdata_reg[31:16];
                mem_we     = we_reg ? hi_mask : 4'h0;
            end
            TAIL: begin
                mem_addr   = {addr_reg, 1'b1};
                state_next = (grant_a || grant_b) ? LO : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            be_reg     <= 4'h0;
            addr_reg   <= 13'h0000;
            wdata_reg  <= 32'h0000_0000;
            port_reg   <= 1'b0;
            last_b_reg <= 1'b1;
            lo_reg     <= 16'h0000;
            rdata_reg  <= 32'h0000_0000;
            a_ack_reg  <= 1'b0;
            b_ack_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_ack_reg <= (state_reg == TAIL) && !port_reg;
            b_ack_reg <= (state_reg == TAIL) && port_reg;
            if (grant_a || grant_b) begin
                we_reg     <= grant_a ? a_we    : b_we;
                be_reg     <= grant_a ? a_be    : b_be;
                addr_reg   <= grant_a ? a_addr  : b_addr;
                wdata_reg  <= grant_a ? a_wdata : b_wdata;
                port_reg   <= grant_b;
                last_b_reg <= grant_b;
            end
            if (state_reg == HI) lo_reg <= mem_rdata;
            // The high half arrives in TAIL; this uses the finishing access's we_reg.
            if ((state_reg == TAIL) && !we_reg) rdata_reg <= {mem_rdata, lo_reg};
        end
    end

    assign a_gnt = grant_a;
    assign b_gnt = grant_b;
    assign a_ack = a_ack_reg;
    assign b_ack = b_ack_reg;
    assign rdata = rdata_reg;

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester controller for the 16K×16 single-port SPRAM.
- Arbitrates between requester A (instruction fetch) and requester B (load/store).
- Turns each granted 32-bit access into two sequenced 16-bit SPRAM cycles: low half, then high half.
- Maps byte enables onto the SPRAM nibble write mask.
- Drives the spram wrapper ports directly and sits between the CPU core and on-chip memory.

## Interface

Parameters:
- PRIO_A, default 0: 0 = round-robin arbitration; 1 = fixed priority, A always wins.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  A requests an access; held with its qualifiers until a_gnt.
- a_we  in  1  A access is a write (1) or read (0).
- a_be  in  4  A byte enables; bit i covers wdata[8i+7:8i].
- a_addr  in  13  A 32-bit word address.
- a_wdata  in  32  A write data.
- a_gnt  out  1  A accepted this cycle; qualifiers are sampled on this edge.
- a_ack  out  1  one-cycle pulse: A transaction complete; rdata valid when it was a read.
- b_req, b_we, b_be, b_addr, b_wdata, b_gnt, b_ack: same as the A ports.
- rdata  out  32  read data; valid in the a_ack/b_ack cycle.
- mem_addr  out  14  to SPRAM addr.
- mem_we  out  4  to SPRAM nibble write mask.
- mem_wdata  out  16  to SPRAM data_in.
- mem_rdata  in  16  from SPRAM data_out; registered, valid the cycle after its address is sampled.

## Operation

States: IDLE, LO, HI, TAIL.

IDLE / TAIL (arbitration points):
- If any req is high, assert the winner's gnt combinationally.
- On that edge, latch the winner's we, be, addr, wdata and port id, then go to LO.
- Otherwise TAIL goes to IDLE.

Arbitration rules:
- Only one req high: that port wins.
- Both high, PRIO_A=1: A wins.
- Both high, PRIO_A=0: the port not granted last wins. The last-grant flag updates on every grant.

Memory cycles:
- LO: mem_addr={addr,0}, mem_wdata=wdata[15:0], mem_we={be1,be1,be0,be0} when we, else 0.
- HI: mem_addr={addr,1}, mem_wdata=wdata[31:16], mem_we={be3,be3,be2,be2} when we, else 0. Capture mem_rdata into lo_reg.
- TAIL: mem_we=0 and mem_addr holds the HI value. On the edge, register rdata={mem_rdata,lo_reg} (reads only) and raise the latched port's ack for the next cycle.

General rules:
- mem_we is 0 in IDLE and TAIL.
- mem_addr and mem_wdata are don't-care in IDLE.
- A write with be=0 still runs LO/HI/TAIL and acks, but writes nothing.
- rdata holds its last value on writes and when idle.
- Never grant a port whose req is low. Never grant both ports in the same cycle.

## Timing

- Grant in cycle G. Then LO is G+1, HI is G+2, TAIL is G+3, and ack pulses in G+4.
- If a req is pending in TAIL (G+3), it is granted in G+3, so its LO is G+4.
- Sustained throughput: one 32-bit access per 3 cycles.
- Read latency from the gnt edge to ack: 4 cycles.
- Write visibility: a read granted in or after the write's TAIL cycle returns the new data.
- Reset values: state=IDLE, a_gnt=b_gnt=0, a_ack=b_ack=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, lo_reg=0, last-grant=B (A wins the first tie).
- Reset asserted mid-transaction:
  - Abort immediately; no ack is issued.
  - mem_we drops to 0 asynchronously.
  - A write aborted after LO may leave only its low half written. This is accepted behaviour.
- Requester rule: dropping req before gnt withdraws the request; no grant results.
- req high in the same cycle as its own ack is a new request and is arbitrated normally.

## Test plan

- Single read: preload word 0x0005 = 0xDEADBEEF (SPRAM halves 0x000A=0xBEEF, 0x000B=0xDEAD). A reads 0x0005 → a_gnt at G, mem_addr 0x000A at G+1 and 0x000B at G+2, a_ack with rdata=0xDEADBEEF at G+4; b_ack stays 0.
- Masked write then readback:
  - B writes 0x0100 with data 0x11223344, be=1111.
  - B then writes 0x0100 with data 0xAABBCCDD, be=0101. Required mem_we: 1100-less form, i.e. 0011 in LO and 0011 in HI.
  - B reads 0x0100 → rdata=0x11BB33DD.
- Contention, round-robin (PRIO_A=0): a_req and b_req held high from reset → grants A,B,A,B, 3 cycles apart; acks alternate a_ack/b_ack every 3 cycles after the first at G+4.
- Fixed priority (PRIO_A=1): both reqs held high → A granted every 3 cycles, b_gnt never asserts. Drop a_req → B is granted at the next arbitration point.
- Reset mid-op: assert rst_n=0 during HI of a read → all outputs at reset values within the same cycle; no ack afterwards. After release, a new A read completes normally with latency 4.
- Zero-mask write: A write with be=0000 to a preloaded word → mem_we=0 in all states, a_ack at G+4, and a readback returns the original value.
